// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Holds the FSM state encoding, the port identifier type, the default
// address/data widths and the round-robin grant helper.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    // Single requester wins outright; on a tie the port that did not win
    // last time is chosen.
    function automatic port_t rr_pick(input logic a_req, input logic b_req,
                                      input port_t last_gnt);
        port_t gnt;
        if (a_req && b_req) begin
            gnt = (last_gnt == PORT_A) ? PORT_B : PORT_A;
        end else if (b_req) begin
            gnt = PORT_B;
        end else begin
            gnt = PORT_A;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with a registered read output.
// Ports:
//   CLK    - clock, all activity on the rising edge
//   EN     - access enable; nothing happens when low
//   WE     - 1 = write WDATA to ADDR, 0 = load RDATA from ADDR
//   ADDR   - word address (2^ADDR_W words)
//   WDATA  - write data
//   RDATA  - output register, changes only on an enabled read
// Contents are not reset.
module sp_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              EN,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge CLK) begin
        if (EN) begin
            if (WE) begin
                mem_q[ADDR] <= WDATA;
            end else begin
                rdata_q <= mem_q[ADDR];
            end
        end
    end

    assign RDATA = rdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one single-port RAM between ports A and B.
// A request sampled in IDLE is latched (port, WE, ADDR, WDATA), executed
// on the RAM in ACCESS and acknowledged with a one-cycle ACK pulse in ACK.
// Ties are broken round-robin using a last-grant register.
// Ports:
//   CLK, RST_N            - clock and synchronous active-low reset
//   A_/B_REQ, _WE, _ADDR, _WDATA - per-port command, held until ACK
//   A_/B_ACK              - one-cycle completion pulse
//   A_/B_RDATA            - per-port read data, changes only on own read
//   BUSY                  - high whenever the FSM is not in IDLE
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_WDATA,
    output logic              A_ACK,
    output logic [DATA_W-1:0] A_RDATA,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_WDATA,
    output logic              B_ACK,
    output logic [DATA_W-1:0] B_RDATA,
    output logic              BUSY
);

    state_t            state_q, state_d;
    port_t             last_gnt_q, last_gnt_d;
    port_t             port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_en;
    port_t             gnt;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        port_d     = port_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        gnt        = rr_pick(A_REQ, B_REQ, last_gnt_q);

        case (state_q)
            ST_IDLE: begin
                if (A_REQ || B_REQ) begin
                    port_d     = gnt;
                    last_gnt_d = gnt;
                    if (gnt == PORT_A) begin
                        we_d    = A_WE;
                        addr_d  = A_ADDR;
                        wdata_d = A_WDATA;
                    end else begin
                        we_d    = B_WE;
                        addr_d  = B_ADDR;
                        wdata_d = B_WDATA;
                    end
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_ACK;
            end
            ST_ACK: begin
                // The RAM output register already holds the read word during
                // ACK; the port's holding register captures it at the end.
                if (!we_q) begin
                    if (port_q == PORT_A) begin
                        a_rdata_d = ram_rdata;
                    end else begin
                        b_rdata_d = ram_rdata;
                    end
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Gating with RST_N makes a reset at the ACCESS edge abort the write.
    assign ram_en = (state_q == ST_ACCESS) && RST_N;

    sp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .CLK   (CLK),
        .EN    (ram_en),
        .WE    (we_q),
        .ADDR  (addr_q),
        .WDATA (wdata_q),
        .RDATA (ram_rdata)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= PORT_B;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    // Latched command; only consumed while the FSM is out of IDLE, so it
    // needs no reset.
    always_ff @(posedge CLK) begin
        port_q  <= port_d;
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign A_ACK = (state_q == ST_ACK) && (port_q == PORT_A);
    assign B_ACK = (state_q == ST_ACK) && (port_q == PORT_B);
    assign BUSY  = (state_q != ST_IDLE);

    // During the ACK of a read the new word is presented straight from the
    // RAM output register; outside that cycle d equals q.
    assign A_RDATA = a_rdata_d;
    assign B_RDATA = b_rdata_d;

endmodule
